tft_spi_sink: RTL

//  SPI responder for the TFT link. It plays the panel end of the ILI9341-style write-only stream our TFT controller emits.

---
 rtl/tft_spi_sink_pkg.sv | 27 ++
 rtl/tft_spi_sink_if.sv | 15 +
 rtl/tft_spi_sink_spi_byte_rx.sv | 99 +++++++++
 rtl/tft_spi_sink.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/tft_spi_sink_pkg.sv
// Shared definitions for the TFT SPI sink: decoder state encoding, the
// ILI9341 command codes it understands, and the command-to-state lookup.
package tft_spi_sink_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PARAM_X,
        ST_PARAM_Y,
        ST_PIXEL,
        ST_IGNORE
    } sink_state_t;

    localparam logic [7:0] ILI9341_CASET = 8'h2A;
    localparam logic [7:0] ILI9341_PASET = 8'h2B;
    localparam logic [7:0] ILI9341_RAMWR = 8'h2C;

    // State the decoder enters when a command byte arrives.
    function automatic sink_state_t cmd_to_state(input logic [7:0] cmd);
        case (cmd)
            ILI9341_CASET: return ST_PARAM_X;
            ILI9341_PASET: return ST_PARAM_Y;
            ILI9341_RAMWR: return ST_PIXEL;
            default:       return ST_IGNORE;
        endcase
    endfunction

endpackage

// File: rtl/tft_spi_sink_if.sv
// Four-wire write-only TFT SPI link (mode 0, MSB first).
//   sclk : SPI clock, idle low
//   mosi : serial data
//   csn  : chip select, active low
//   dcn  : 0 = command byte, 1 = data byte
// master = controller side (drives everything), slave = panel/sink side.
interface tft_spi_sink_if;
    logic sclk;
    logic mosi;
    logic csn;
    logic dcn;

    modport master (output sclk, output mosi, output csn, output dcn);
    modport slave  (input  sclk, input  mosi, input  csn, input  dcn);
endinterface

// File: rtl/tft_spi_sink_spi_byte_rx.sv
// Generic SPI mode-0 byte receiver.
// Inputs are synchronised into clk, rising sclk is edge-detected and mosi is
// shifted in MSB first while csn is low. A completed byte is presented with a
// one-cycle byte_rdy pulse together with the dcn level seen at its 8th bit.
// csn high resets the bit counter so a partial byte is never emitted.
// Ports:
//   clk, rstn            : system clock, async active-low reset
//   sclk, mosi, csn, dcn : raw asynchronous SPI pins
//   byte_rdy             : 1-cycle strobe, byte_data/byte_dc valid
//   byte_data, byte_dc   : received byte and its data/command flag
//   csn_rise             : 1-cycle strobe when chip select is released,
//                          aligned to the same pipeline stage as byte_rdy
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       csn,
    input  logic       dcn,
    output logic       byte_rdy,
    output logic [7:0] byte_data,
    output logic       byte_dc,
    output logic       csn_rise
);

    // Packed as {dcn, csn, mosi, sclk}; csn resets high (deselected) so no
    // spurious chip-select edge is seen when reset is released.
    localparam logic [3:0] SYNC_RST = 4'b0100;

    logic [3:0] stage_d [SYNC_STAGES];
    logic [3:0] stage_q [SYNC_STAGES];

    assign stage_d[0] = {dcn, csn, mosi, sclk};

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi > 0) begin : g_link
                assign stage_d[gi] = stage_q[gi-1];
            end
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) stage_q[gi] <= SYNC_RST;
                else       stage_q[gi] <= stage_d[gi];
            end
        end
    endgenerate

    logic sclk_s, mosi_s, csn_s, dcn_s;
    assign {dcn_s, csn_s, mosi_s, sclk_s} = stage_q[SYNC_STAGES-1];

    logic       sclk_d_reg;
    logic       csn_d_reg;
    logic [6:0] shift_reg;
    logic [2:0] cnt_reg;
    logic       byte_rdy_reg;
    logic [7:0] byte_reg;
    logic       dc_reg;
    logic       csn_rise_reg;

    logic sclk_rise;
    assign sclk_rise = sclk_s & ~sclk_d_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_d_reg   <= 1'b0;
            csn_d_reg    <= 1'b1;
            shift_reg    <= '0;
            cnt_reg      <= '0;
            byte_rdy_reg <= 1'b0;
            byte_reg     <= '0;
            dc_reg       <= 1'b0;
            csn_rise_reg <= 1'b0;
        end else begin
            sclk_d_reg   <= sclk_s;
            csn_d_reg    <= csn_s;
            byte_rdy_reg <= 1'b0;
            csn_rise_reg <= csn_s & ~csn_d_reg;
            if (csn_s) begin
                cnt_reg <= '0;
            end else if (sclk_rise) begin
                shift_reg <= {shift_reg[5:0], mosi_s};
                cnt_reg   <= cnt_reg + 3'd1;
                if (cnt_reg == 3'd7) begin
                    byte_rdy_reg <= 1'b1;
                    byte_reg     <= {shift_reg, mosi_s};
                    dc_reg       <= dcn_s;
                end
            end
        end
    end

    assign byte_rdy  = byte_rdy_reg;
    assign byte_data = byte_reg;
    assign byte_dc   = dc_reg;
    assign csn_rise  = csn_rise_reg;

endmodule

// File: rtl/tft_spi_sink.sv
// Panel-side sink for the ILI9341-style TFT write stream.
// Decodes CASET/PASET (window) and RAMWR (pixel data), tracking the pixel
// address and emitting one strobe per 16-bit colour (low byte first).
// Ports:
//   clk, rstn      : system clock (>= 4x sclk), async active-low reset
//   spi            : SPI link, slave side
//   cmd_valid      : 1-cycle strobe per command byte; cmd_byte holds it
//   pix_valid      : 1-cycle strobe per pixel with pix_x/pix_y/pix_color
//   win_ovf        : pixels written after the window was exhausted (sat.)
//   ign_cnt        : unsupported command bytes received (sat.)
module tft_spi_sink
    import tft_spi_sink_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    tft_spi_sink_if.slave        spi,
    output logic                 cmd_valid,
    output logic [7:0]           cmd_byte,
    output logic                 pix_valid,
    output logic [15:0]          pix_x,
    output logic [15:0]          pix_y,
    output logic [15:0]          pix_color,
    output logic [CNT_WIDTH-1:0] win_ovf,
    output logic [CNT_WIDTH-1:0] ign_cnt
);

    logic       byte_rdy;
    logic [7:0] byte_data;
    logic       byte_dc;
    logic       csn_rise;

    spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
        .clk       (clk),
        .rstn      (rstn),
        .sclk      (spi.sclk),
        .mosi      (spi.mosi),
        .csn       (spi.csn),
        .dcn       (spi.dcn),
        .byte_rdy  (byte_rdy),
        .byte_data (byte_data),
        .byte_dc   (byte_dc),
        .csn_rise  (csn_rise)
    );

    sink_state_t          state_reg,     state_next;
    logic [1:0]           pcnt_reg,      pcnt_next;
    logic [15:0]          start_reg,     start_next;
    logic [7:0]           end_hi_reg,    end_hi_next;
    logic [15:0]          xs_reg,        xs_next;
    logic [15:0]          xe_reg,        xe_next;
    logic [15:0]          ys_reg,        ys_next;
    logic [15:0]          ye_reg,        ye_next;
    logic [15:0]          cur_x_reg,     cur_x_next;
    logic [15:0]          cur_y_reg,     cur_y_next;
    logic                 half_reg,      half_next;
    logic [7:0]           lo_reg,        lo_next;
    logic                 exh_reg,       exh_next;
    logic                 cmd_valid_reg, cmd_valid_next;
    logic [7:0]           cmd_byte_reg,  cmd_byte_next;
    logic                 pix_valid_reg, pix_valid_next;
    logic [15:0]          pix_x_reg,     pix_x_next;
    logic [15:0]          pix_y_reg,     pix_y_next;
    logic [15:0]          pix_color_reg, pix_color_next;
    logic [CNT_WIDTH-1:0] ovf_reg,       ovf_next;
    logic [CNT_WIDTH-1:0] ign_reg,       ign_next;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= ST_IDLE;
            pcnt_reg      <= '0;
            start_reg     <= '0;
            end_hi_reg    <= '0;
            xs_reg        <= '0;
            xe_reg        <= '0;
            ys_reg        <= '0;
            ye_reg        <= '0;
            cur_x_reg     <= '0;
            cur_y_reg     <= '0;
            half_reg      <= 1'b0;
            lo_reg        <= '0;
            exh_reg       <= 1'b0;
            cmd_valid_reg <= 1'b0;
            cmd_byte_reg  <= '0;
            pix_valid_reg <= 1'b0;
            pix_x_reg     <= '0;
            pix_y_reg     <= '0;
            pix_color_reg <= '0;
            ovf_reg       <= '0;
            ign_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            pcnt_reg      <= pcnt_next;
            start_reg     <= start_next;
            end_hi_reg    <= end_hi_next;
            xs_reg        <= xs_next;
            xe_reg        <= xe_next;
            ys_reg        <= ys_next;
            ye_reg        <= ye_next;
            cur_x_reg     <= cur_x_next;
            cur_y_reg     <= cur_y_next;
            half_reg      <= half_next;
            lo_reg        <= lo_next;
            exh_reg       <= exh_next;
            cmd_valid_reg <= cmd_valid_next;
            cmd_byte_reg  <= cmd_byte_next;
            pix_valid_reg <= pix_valid_next;
            pix_x_reg     <= pix_x_next;
            pix_y_reg     <= pix_y_next;
            pix_color_reg <= pix_color_next;
            ovf_reg       <= ovf_next;
            ign_reg       <= ign_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pcnt_next      = pcnt_reg;
        start_next     = start_reg;
        end_hi_next    = end_hi_reg;
        xs_next        = xs_reg;
        xe_next        = xe_reg;
        ys_next        = ys_reg;
        ye_next        = ye_reg;
        cur_x_next     = cur_x_reg;
        cur_y_next     = cur_y_reg;
        half_next      = half_reg;
        lo_next        = lo_reg;
        exh_next       = exh_reg;
        cmd_valid_next = 1'b0;
        cmd_byte_next  = cmd_byte_reg;
        pix_valid_next = 1'b0;
        pix_x_next     = pix_x_reg;
        pix_y_next     = pix_y_reg;
        pix_color_next = pix_color_reg;
        ovf_next       = ovf_reg;
        ign_next       = ign_reg;

        if (byte_rdy) begin
            if (!byte_dc) begin
                // Any command aborts whatever was in progress.
                cmd_valid_next = 1'b1;
                cmd_byte_next  = byte_data;
                pcnt_next      = '0;
                half_next      = 1'b0;
                state_next     = cmd_to_state(byte_data);
                case (state_next)
                    ST_PIXEL: begin
                        cur_x_next = xs_reg;
                        cur_y_next = ys_reg;
                        exh_next   = 1'b0;
                    end
                    ST_IGNORE: begin
                        if (~&ign_reg) ign_next = ign_reg + CNT_WIDTH'(1);
                    end
                    default: ;
                endcase
            end else begin
                case (state_reg)
                    ST_PARAM_X, ST_PARAM_Y: begin
                        pcnt_next = pcnt_reg + 2'd1;
                        case (pcnt_reg)
                            2'd0: start_next[15:8] = byte_data;
                            2'd1: start_next[7:0]  = byte_data;
                            2'd2: end_hi_next      = byte_data;
                            default: begin
                                // Window only changes once all four bytes are in.
                                if (state_reg == ST_PARAM_X) begin
                                    xs_next = start_reg;
                                    xe_next = {end_hi_reg, byte_data};
                                end else begin
                                    ys_next = start_reg;
                                    ye_next = {end_hi_reg, byte_data};
                                end
                                state_next = ST_IDLE;
                            end
                        endcase
                    end
                    ST_PIXEL: begin
                        if (!half_reg) begin
                            lo_next   = byte_data;
                            half_next = 1'b1;
                        end else begin
                            half_next      = 1'b0;
                            pix_valid_next = 1'b1;
                            pix_x_next     = cur_x_reg;
                            pix_y_next     = cur_y_reg;
                            pix_color_next = {byte_data, lo_reg};
                            if (exh_reg && ~&ovf_reg) ovf_next = ovf_reg + CNT_WIDTH'(1);
                            if (cur_x_reg == xe_reg) begin
                                cur_x_next = xs_reg;
                                if (cur_y_reg == ye_reg) begin
                                    // Last cell written: wrap to the origin
                                    // and count everything after as overflow.
                                    cur_y_next = ys_reg;
                                    exh_next   = 1'b1;
                                end else begin
                                    cur_y_next = cur_y_reg + 16'd1;
                                end
                            end else begin
                                cur_x_next = cur_x_reg + 16'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        // End of a csn frame drops a half-received pixel; the state persists.
        if (csn_rise) half_next = 1'b0;
    end

    assign cmd_valid = cmd_valid_reg;
    assign cmd_byte  = cmd_byte_reg;
    assign pix_valid = pix_valid_reg;
    assign pix_x     = pix_x_reg;
    assign pix_y     = pix_y_reg;
    assign pix_color = pix_color_reg;
    assign win_ovf   = ovf_reg;
    assign ign_cnt   = ign_reg;

endmodule
